// File: rtl/bitstream_classifier_if.sv
// Handshake/bus bundle between the classifier and its requester/consumer.
// Latency: none (wires only).
// Backpressure: result_ready from the consumer holds the result in place.
interface bitstream_classifier_if #(
  parameter int OUTPUT_SIZE = 3,
  parameter int WINDOW      = 256
);
  localparam int COUNT_W = $clog2(WINDOW + 1);
  localparam int CLASS_W = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

  logic                   start;
  logic [OUTPUT_SIZE-1:0] bitstream_in;
  logic                   busy;
  logic                   result_valid;
  logic                   result_ready;
  logic [CLASS_W-1:0]     class_out;
  logic [COUNT_W-1:0]     class_count;
  logic                   tie;

  // Requester/consumer side.
  modport master (
    output start, bitstream_in, result_ready,
    input  busy, result_valid, class_out, class_count, tie
  );

  // Classifier side.
  modport slave (
    input  start, bitstream_in, result_ready,
    output busy, result_valid, class_out, class_count, tie
  );
endinterface

// File: rtl/bitstream_classifier.sv
// Counts ones per channel over a window after a discard period, then argmax.
// Latency: start at edge t -> result_valid visible in cycle t+DISCARD+WINDOW+OUTPUT_SIZE+1.
// Backpressure: result held in HOLD until result_valid & result_ready; start ignored unless IDLE.
module bitstream_classifier #(
  parameter int OUTPUT_SIZE = 3,
  parameter int WINDOW      = 256,
  parameter int DISCARD     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  bitstream_classifier_if.slave  bus
);
  localparam int COUNT_W = $clog2(WINDOW + 1);
  localparam int CLASS_W = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  // One cycle counter is shared by the DISCARD, COUNT and SCAN phases.
  localparam int MAX_CYC = (WINDOW > DISCARD)
                           ? ((WINDOW > OUTPUT_SIZE) ? WINDOW : OUTPUT_SIZE)
                           : ((DISCARD > OUTPUT_SIZE) ? DISCARD : OUTPUT_SIZE);
  localparam int CYC_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DISCARD = 3'd1,
    S_COUNT   = 3'd2,
    S_SCAN    = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [COUNT_W-1:0] cnt_q [OUTPUT_SIZE];
  logic [COUNT_W-1:0] cnt_d [OUTPUT_SIZE];
  logic [COUNT_W-1:0] best_q, best_d;
  logic [CLASS_W-1:0] cls_q, cls_d;
  logic               tie_q, tie_d;
  logic [COUNT_W-1:0] scan_val;
  logic               last_disc, last_win, last_scan;

  assign last_disc = (cyc_q == CYC_W'(DISCARD - 1));
  assign last_win  = (cyc_q == CYC_W'(WINDOW - 1));
  assign last_scan = (cyc_q == CYC_W'(OUTPUT_SIZE - 1));

  // State register; reset abandons any inference in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: phase lengths are all measured by the shared cycle counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.start) state_d = (DISCARD > 0) ? S_DISCARD : S_COUNT;
      S_DISCARD: if (last_disc) state_d = S_COUNT;
      S_COUNT:   if (last_win) state_d = S_SCAN;
      S_SCAN:    if (last_scan) state_d = S_HOLD;
      S_HOLD:    if (bus.result_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath: clear on start, accumulate during COUNT, one channel per SCAN cycle.
  always_comb begin
    cyc_d    = cyc_q;
    cnt_d    = cnt_q;
    best_d   = best_q;
    cls_d    = cls_q;
    tie_d    = tie_q;
    scan_val = '0;
    for (int k = 0; k < OUTPUT_SIZE; k++) begin
      if (cyc_q == CYC_W'(k)) scan_val = cnt_q[k];
    end
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cyc_d = '0;
          for (int k = 0; k < OUTPUT_SIZE; k++) cnt_d[k] = '0;
        end
      end
      S_DISCARD: begin
        cyc_d = last_disc ? '0 : cyc_q + CYC_W'(1);
      end
      S_COUNT: begin
        for (int k = 0; k < OUTPUT_SIZE; k++) begin
          cnt_d[k] = cnt_q[k] + COUNT_W'(bus.bitstream_in[k]);
        end
        cyc_d = last_win ? '0 : cyc_q + CYC_W'(1);
      end
      S_SCAN: begin
        // Strict greater-than keeps the lowest index on equal counts.
        if (cyc_q == '0) begin
          best_d = scan_val;
          cls_d  = '0;
          tie_d  = 1'b0;
        end else if (scan_val > best_q) begin
          best_d = scan_val;
          cls_d  = CLASS_W'(cyc_q);
          tie_d  = 1'b0;
        end else if (scan_val == best_q) begin
          tie_d  = 1'b1;
        end
        cyc_d = cyc_q + CYC_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q  <= '0;
      best_q <= '0;
      cls_q  <= '0;
      tie_q  <= 1'b0;
      for (int k = 0; k < OUTPUT_SIZE; k++) cnt_q[k] <= '0;
    end else begin
      cyc_q  <= cyc_d;
      best_q <= best_d;
      cls_q  <= cls_d;
      tie_q  <= tie_d;
      cnt_q  <= cnt_d;
    end
  end

  // Outputs: result fields hold their last values outside HOLD.
  always_comb begin
    bus.busy         = (state_q != S_IDLE);
    bus.result_valid = (state_q == S_HOLD);
    bus.class_out    = cls_q;
    bus.class_count  = best_q;
    bus.tie          = tie_q;
  end
endmodule

// File: tb/tb_bitstream_classifier.sv
// Bench for bitstream_classifier: directed plan cases plus randomized runs vs a counting model.
// Latency: measured per inference against DISCARD+WINDOW+OUTPUT_SIZE+1.
// Backpressure: exercises early ready, held results with start pulses, and mid-COUNT reset.
module tb_bitstream_classifier;
  localparam int N     = 3;
  localparam int W     = 256;
  localparam int D     = 4;
  localparam int LAT   = D + W + N + 1;
  localparam int LIMIT = LAT + 50;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   m_cnt [N];
  int   e_cls, e_cnt, e_tie;

  bitstream_classifier_if #(.OUTPUT_SIZE(N), .WINDOW(W)) bus ();

  bitstream_classifier #(.OUTPUT_SIZE(N), .WINDOW(W), .DISCARD(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Bit pattern per mode; j is the index within the COUNT window.
  function automatic logic [2:0] gen(input int mode, input bit disc, input int j);
    logic [2:0] v;
    v = 3'($urandom);
    case (mode)
      1: v = 3'b010;
      2: v = 3'b000;
      3: if (!disc) v = {((j % 4) != 3), 1'b0, ((j % 2) == 0)};
      4: v = 3'b101;
      5: v = disc ? 3'b010 : 3'b001;
      6: v = {(($urandom % 8) < 5), (($urandom % 8) < 3), (($urandom % 2) == 1)};
      7: v[2] = v[0];
      default: ;
    endcase
    return v;
  endfunction

  // Pulse start and feed DISCARD + nsamp cycles; n counts cycles since the start edge.
  task automatic launch(input int mode, input int nsamp, output int n);
    logic [2:0] v;
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    for (int j = 0; j < D + nsamp; j++) begin
      v = gen(mode, j < D, j - D);
      bus.bitstream_in = v;
      if (j >= D) for (int k = 0; k < N; k++) m_cnt[k] += int'(v[k]);
      @(negedge clk);
      n++;
    end
    bus.bitstream_in = 3'($urandom);
  endtask

  task automatic wait_valid(inout int n);
    while (bus.result_valid !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Reference: highest count, lowest index among equals, tie if several share it.
  task automatic model();
    int nmax;
    e_cnt = -1;
    e_cls = 0;
    nmax  = 0;
    for (int k = 0; k < N; k++) if (m_cnt[k] > e_cnt) e_cnt = m_cnt[k];
    for (int k = N - 1; k >= 0; k--) begin
      if (m_cnt[k] == e_cnt) begin
        e_cls = k;
        nmax++;
      end
    end
    e_tie = (nmax > 1) ? 1 : 0;
  endtask

  task automatic check_result(input string tag, input int n, input int cls, input int cnt, input int t);
    chk({tag, ".latency"}, n, LAT);
    chk({tag, ".class_out"}, bus.class_out, cls);
    chk({tag, ".class_count"}, bus.class_count, cnt);
    chk({tag, ".tie"}, bus.tie, t);
    chk({tag, ".busy"}, bus.busy, 1);
  endtask

  task automatic handshake(input string tag);
    bus.result_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".valid_after_hs"}, bus.result_valid, 0);
    chk({tag, ".busy_after_hs"}, bus.busy, 0);
    bus.result_ready = 1'b0;
  endtask

  task automatic directed(input string tag, input int mode, input bit early,
                          input int cls, input int cnt, input int t);
    int n;
    bus.result_ready = early;
    launch(mode, W, n);
    wait_valid(n);
    model();
    chk({tag, ".model_count"}, e_cnt, cnt);
    check_result(tag, n, cls, cnt, t);
    handshake(tag);
    @(negedge clk);
  endtask

  initial begin
    int n;
    n_checks         = 0;
    n_pass           = 0;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.bitstream_in = '0;
    bus.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.busy", bus.busy, 0);
    chk("reset.valid", bus.result_valid, 0);
    chk("reset.class_out", bus.class_out, 0);
    chk("reset.class_count", bus.class_count, 0);
    chk("reset.tie", bus.tie, 0);
    rst = 1'b0;
    @(negedge clk);

    directed("const010", 1, 1'b0, 1, 256, 0);
    directed("all_zero", 2, 1'b1, 0, 0, 1);
    directed("alt_3of4", 3, 1'b0, 2, 192, 0);
    directed("ch0_ch2", 4, 1'b1, 0, 256, 1);
    directed("discard", 5, 1'b0, 0, 256, 0);

    // Held result under backpressure with start pulses.
    bus.result_ready = 1'b0;
    launch(3, W, n);
    wait_valid(n);
    check_result("bp", n, 2, 192, 0);
    for (int i = 0; i < 10; i++) begin
      bus.start = (i % 2 == 0);
      @(negedge clk);
      chk("bp.hold_valid", bus.result_valid, 1);
      chk("bp.hold_busy", bus.busy, 1);
      chk("bp.hold_class", bus.class_out, 2);
      chk("bp.hold_count", bus.class_count, 192);
    end
    bus.start        = 1'b1;
    bus.result_ready = 1'b1;
    @(negedge clk);
    chk("bp.valid_after_hs", bus.result_valid, 0);
    chk("bp.busy_after_hs", bus.busy, 0);
    bus.start        = 1'b0;
    bus.result_ready = 1'b0;
    @(negedge clk);
    chk("bp.no_restart", bus.busy, 0);
    chk("bp.idle_hold_class", bus.class_out, 2);

    // Reset during COUNT after 100 samples.
    launch(0, 100, n);
    rst = 1'b1;
    @(negedge clk);
    chk("abort.busy", bus.busy, 0);
    chk("abort.valid", bus.result_valid, 0);
    chk("abort.class_count", bus.class_count, 0);
    rst = 1'b0;
    @(negedge clk);
    launch(6, W, n);
    wait_valid(n);
    model();
    check_result("abort.rerun", n, e_cls, e_cnt, e_tie);
    handshake("abort.rerun");

    // Randomized inferences checked against the counting model.
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.result_ready = $urandom_range(0, 1);
      launch((r % 3 == 0) ? 0 : ((r % 3 == 1) ? 6 : 7), W, n);
      wait_valid(n);
      model();
      check_result("rand", n, e_cls, e_cnt, e_tie);
      handshake("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bitstream_classifier.md
Name: bitstream_classifier

Overview:
- Sits directly downstream of the stochastic bitstream network; consumes its raw OUTPUT_SIZE-bit output bitstream vector.
- On request, discards a fixed number of pipeline-fill cycles, then counts ones per output channel over a fixed window.
- Then runs a sequential argmax over the per-channel counts and presents the winning class index with a valid/ready handshake.
- Replaces free-running integrators when a single classification decision per inference is required.

Parameters:
- OUTPUT_SIZE, 3, number of network output channels (>=1)
- WINDOW, 256, number of sampled bitstream cycles per inference (>=1)
- DISCARD, 4, cycles skipped after start before sampling begins (>=0)
- COUNT_W, $clog2(WINDOW+1), per-channel ones-counter width (derived)
- CLASS_W, (OUTPUT_SIZE>1) ? $clog2(OUTPUT_SIZE) : 1, class index width (derived)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  inference request; sampled only in IDLE
- bitstream_in  input  OUTPUT_SIZE  network output bitstream, one bit per channel per cycle
- busy  output  1  high whenever state != IDLE
- result_valid  output  1  class result available
- result_ready  input  1  consumer accepts result
- class_out  output  CLASS_W  index of the winning channel
- class_count  output  COUNT_W  ones-count of the winning channel
- tie  output  1  another channel's count equals the winning count

Behaviour:
- Reset (rst high at a clock edge): state=IDLE; all counters, class_out, class_count, tie and result_valid=0; busy=0. Reset at any point, including mid-COUNT or HOLD, aborts the operation with no result produced.
- States: IDLE -> DISCARD -> COUNT -> SCAN -> HOLD -> IDLE.
- IDLE: on start=1 at edge t, clear all channel counters and the cycle counter. Go to DISCARD, or directly to COUNT if DISCARD=0.
- DISCARD: cycles t+1..t+DISCARD; bitstream_in ignored.
- COUNT: exactly WINDOW cycles. Each cycle, counter[k] += bitstream_in[k] for every k. After the WINDOW-th sample, go to SCAN.
  - Counters cannot overflow, because max value WINDOW fits in COUNT_W; no saturation logic.
- SCAN: OUTPUT_SIZE cycles with index i=0..OUTPUT_SIZE-1.
  - i=0: best=counter[0], class=0, tie=0, unconditionally.
  - i>0, counter[i] > best: best=counter[i], class=i, tie=0.
  - i>0, counter[i] == best: tie=1; class is unchanged, so the lowest index wins ties.
  - i>0, counter[i] < best: no change.
- HOLD: result_valid=1. class_out, class_count and tie are stable until a handshake (result_valid & result_ready at an edge). The next state after the handshake is IDLE with result_valid=0.
  - result_ready may be high before valid; the handshake then completes on the first HOLD cycle.
- Latency: with start accepted at edge t, result_valid rises at t+DISCARD+WINDOW+OUTPUT_SIZE+1. Defaults give t+264.
- start is ignored in every state except IDLE, including during the handshake cycle. A new start is accepted no earlier than the cycle after returning to IDLE.
- class_out, class_count and tie hold their last values in IDLE until the next SCAN overwrites them. They are meaningful only while result_valid=1.
- OUTPUT_SIZE=1: SCAN lasts 1 cycle; class_out=0 and tie=0 always.

Test Plan:
- Defaults, bitstream_in=3'b010 constant, start pulse at t -> result_valid rises at t+264, class_out=1, class_count=256, tie=0.
- bitstream_in=0 constant -> class_out=0, class_count=0, tie=1.
- ch0 high on alternate COUNT cycles (128), ch1=0, ch2 high 3 of every 4 cycles (192) -> class_out=2, class_count=192, tie=0.
- ch0 and ch2 high throughout, ch1=0 -> class_out=0, class_count=256, tie=1.
- Discard window: ch1=1 only during the 4 DISCARD cycles, ch0=1 during COUNT -> class_out=0, class_count=256, tie=0 (ch1 count must be 0).
- Backpressure and abort:
  - result_ready=0 for 10 HOLD cycles while start pulses -> outputs unchanged, busy=1, no restart; result_ready=1 -> IDLE next cycle.
  - Separately, rst at COUNT cycle 100 -> busy=0 and result_valid=0 next cycle; a subsequent start yields a full-latency result.
